// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
// Stored segment patterns are always active-high {dp,g,f,e,d,c,b,a}.
// Pin polarity is applied only at the output registers.
package display_pkg;

    // Brightness code meaning "always on" (no PWM gating).
    localparam logic [3:0] BRIGHT_FULL = 4'hF;

    // Widest anode bus the driver supports.
    localparam int unsigned MAX_DIGITS = 16;

    // Number of bits needed to index 'value' entries (minimum 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned remaining;
        result    = 0;
        remaining = (value > 1) ? value - 1 : 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Segment bus value with every segment unlit.
    function automatic logic [7:0] seg_all_off(input logic active_low);
        return active_low ? 8'hFF : 8'h00;
    endfunction

    // Anode bus value with every digit deselected (caller slices to its width).
    function automatic logic [MAX_DIGITS-1:0] an_all_off(input logic active_low);
        return {MAX_DIGITS{active_low}};
    endfunction

    // Convert an active-high stored pattern into pin levels.
    function automatic logic [7:0] seg_drive(input logic [7:0] pattern, input logic active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/display_nmux_pwm_if.sv
// Write port into the digit pattern buffer.
// The writer (keypad/control logic) is the master; the display driver is the slave.
interface display_nmux_pwm_if #(
    parameter int unsigned AW = 2
);
    logic          load;        // one cycle high = one write
    logic [AW-1:0] bufdestino;  // digit index being written
    logic [7:0]    datai;       // active-high pattern {dp,g..a}

    modport master (
        output load,
        output bufdestino,
        output datai
    );

    modport slave (
        input load,
        input bufdestino,
        input datai
    );
endinterface

// File: rtl/scan_timer.sv
// Scan timebase for the multiplexed display: prescaler, digit index, blink counter.
// The digit index advances when the prescaler reaches its maximum and wraps at
// NUM_DIGITS-1, so non-power-of-two digit counts never visit unused indices.
// 'wrap' is high for the first cycle in which the index is back at digit 0.
module scan_timer
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned SCAN_DIV_LOG2 = 14,
    parameter int unsigned BLINK_LOG2    = 9,
    localparam int unsigned AW           = clog2(NUM_DIGITS)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [3:0]    pwm_phase,    // top four prescaler bits, drives brightness PWM
    output logic [AW-1:0] idx,          // digit currently in its slot
    output logic          blink_phase,  // 1 = blinking digits hidden
    output logic          wrap          // first cycle of a new frame
);

    localparam int unsigned   LAST_DIGIT = NUM_DIGITS - 1;
    localparam logic [AW-1:0] IDX_LAST   = LAST_DIGIT[AW-1:0];

    logic [SCAN_DIV_LOG2-1:0] pre_cnt_q, pre_cnt_d;
    logic [AW-1:0]            idx_q, idx_d;
    logic [BLINK_LOG2-1:0]    blink_cnt_q, blink_cnt_d;
    logic                     wrap_q;
    logic                     slot_end;
    logic                     frame_end;

    assign slot_end  = &pre_cnt_q;
    assign frame_end = slot_end && (idx_q == IDX_LAST);

    // Next-state: free-running prescaler, slot advance, frame count for blinking.
    always_comb begin
        pre_cnt_d   = pre_cnt_q + 1'b1;
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q;
        if (slot_end) begin
            idx_d = frame_end ? '0 : idx_q + 1'b1;
        end
        if (frame_end) begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    // Timebase state, synchronous reset restarts the scan at digit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt_q   <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            wrap_q      <= 1'b0;
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            wrap_q      <= frame_end;
        end
    end

    assign pwm_phase   = pre_cnt_q[SCAN_DIV_LOG2-1 -: 4];
    assign idx         = idx_q;
    assign blink_phase = blink_cnt_q[BLINK_LOG2-1];
    assign wrap        = wrap_q;

endmodule

// File: rtl/display_nmux_pwm.sv
// Time-multiplexed common-anode 7-segment driver with per-digit blink and
// 16-level brightness PWM. Holds one active-high pattern per digit, written
// through the slave side of display_nmux_pwm_if. All pin outputs are registered:
// the value after edge k+1 is derived from the state after edge k.
module display_nmux_pwm
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV_LOG2  = 14,
    parameter int unsigned BLINK_LOG2     = 9,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    localparam int unsigned AW            = clog2(NUM_DIGITS)
) (
    input  logic                  reloj,
    input  logic                  reset,
    display_nmux_pwm_if.slave     wr,
    input  logic [3:0]            brightness,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    output logic [7:0]            disp_7seg_a_g_dp,
    output logic [NUM_DIGITS-1:0] anodos,
    output logic                  frame_tick
);

    localparam logic [MAX_DIGITS-1:0] AN_OFF_ALL    = an_all_off(AN_ACTIVE_LOW);
    localparam logic [NUM_DIGITS-1:0] AN_OFF        = AN_OFF_ALL[NUM_DIGITS-1:0];
    localparam logic [7:0]            SEG_OFF       = seg_all_off(SEG_ACTIVE_LOW);
    localparam logic [AW:0]           DIGITS_LIMIT  = NUM_DIGITS[AW:0];

    // Timebase outputs
    logic [3:0]    pwm_phase;
    logic [AW-1:0] scan_idx;
    logic          blink_phase;
    logic          frame_start;

    // Pattern buffer and write qualification
    logic [7:0]    digit_buf_q [NUM_DIGITS];
    logic          wr_valid;

    // Gating and output registers
    logic                  pwm_on;
    logic                  blanked;
    logic                  digit_lit;
    logic [NUM_DIGITS-1:0] anode_sel;
    logic [NUM_DIGITS-1:0] anodos_d, anodos_q;
    logic [7:0]            seg_d, seg_q;
    logic                  frame_tick_q;

    scan_timer #(
        .NUM_DIGITS    (NUM_DIGITS),
        .SCAN_DIV_LOG2 (SCAN_DIV_LOG2),
        .BLINK_LOG2    (BLINK_LOG2)
    ) u_scan_timer (
        .clk         (reloj),
        .reset       (reset),
        .pwm_phase   (pwm_phase),
        .idx         (scan_idx),
        .blink_phase (blink_phase),
        .wrap        (frame_start)
    );

    // Writes to indices beyond the last digit are dropped.
    assign wr_valid = wr.load && ({1'b0, wr.bufdestino} < DIGITS_LIMIT);

    // Pattern buffer: one write per load strobe, cleared by reset.
    always_ff @(posedge reloj) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_buf_q[i] <= 8'h00;
            end
        end else if (wr_valid) begin
            digit_buf_q[wr.bufdestino] <= wr.datai;
        end
    end

    // Brightness PWM and blink gating for the digit in its slot.
    always_comb begin
        pwm_on    = (brightness == BRIGHT_FULL) || (pwm_phase < brightness);
        blanked   = blink_mask[scan_idx] & blink_phase;
        digit_lit = pwm_on & ~blanked;
    end

    // Next pin values; segments are blanked whenever the anode is off to avoid ghosting.
    always_comb begin
        anode_sel           = '0;
        anode_sel[scan_idx] = 1'b1;
        if (digit_lit) begin
            anodos_d = AN_ACTIVE_LOW ? ~anode_sel : anode_sel;
            seg_d    = seg_drive(digit_buf_q[scan_idx], SEG_ACTIVE_LOW);
        end else begin
            anodos_d = AN_OFF;
            seg_d    = SEG_OFF;
        end
    end

    // Output registers; reset forces everything dark on the same edge.
    always_ff @(posedge reloj) begin
        if (reset) begin
            anodos_q     <= AN_OFF;
            seg_q        <= SEG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            anodos_q     <= anodos_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_start;
        end
    end

    assign anodos           = anodos_q;
    assign disp_7seg_a_g_dp = seg_q;
    assign frame_tick       = frame_tick_q;

endmodule

// File: tb/tb_display_nmux_pwm.sv
// Bench for display_nmux_pwm with NUM_DIGITS=3, SCAN_DIV_LOG2=4, BLINK_LOG2=2.
// A predictor derives every output cycle from the cycle count since reset and
// queues it; a checker pops and compares on the falling edge. A table of
// brightness/blink settings is checked by counting lit cycles per digit.
module tb_display_nmux_pwm;

    typedef struct {
        logic [2:0] an;
        logic [7:0] seg;
        logic       tick;
    } exp_t;

    typedef struct {
        logic [3:0] bright;
        logic [2:0] mask;
        int         lit0;
        int         lit1;
        int         lit2;
        int         ticks;
    } row_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] brightness;
    logic [2:0] blink_mask;
    logic [7:0] segs;
    logic [2:0] anodos;
    logic       frame_tick;

    int total = 0;
    int bad   = 0;

    exp_t       sb_q[$];
    int         m_c;
    logic [7:0] m_buf [3];

    always #5 clk = ~clk;

    display_nmux_pwm_if #(.AW(2)) wr ();

    display_nmux_pwm #(
        .NUM_DIGITS     (3),
        .SCAN_DIV_LOG2  (4),
        .BLINK_LOG2     (2),
        .AN_ACTIVE_LOW  (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .reloj            (clk),
        .reset            (reset),
        .wr               (wr),
        .brightness       (brightness),
        .blink_mask       (blink_mask),
        .disp_7seg_a_g_dp (segs),
        .anodos           (anodos),
        .frame_tick       (frame_tick)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Predictor: at each rising edge, queue what this edge must produce.
    initial begin
        exp_t       e;
        int         pre;
        int         idx;
        int         phase;
        logic       on;
        logic       lit;
        logic [2:0] sel;
        m_c = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                e.an  = 3'b111;
                e.seg = 8'hFF;
                e.tick = 1'b0;
                m_c   = 0;
                for (int i = 0; i < 3; i++) m_buf[i] = 8'h00;
            end else begin
                pre   = m_c % 16;
                idx   = (m_c / 16) % 3;
                phase = ((m_c / 48) / 2) % 2;
                on    = (brightness == 4'hF) || (pre < int'(brightness));
                lit   = on && !(blink_mask[idx] && phase == 1);
                sel   = 3'b001 << idx;
                e.an  = lit ? ~sel : 3'b111;
                e.seg = lit ? ~m_buf[idx] : 8'hFF;
                e.tick = (m_c > 0) && (m_c % 48 == 0);
                if (wr.load && wr.bufdestino != 2'd3) m_buf[wr.bufdestino] = wr.datai;
                m_c++;
            end
            sb_q.push_back(e);
        end
    end

    // Checker: compare queued expectations away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_anodos", 16'(anodos), 16'(e.an));
                check("sb_segs", 16'(segs), 16'(e.seg));
                check("sb_tick", 16'(frame_tick), 16'(e.tick));
            end
        end
    end

    task automatic wait_tick(input string name);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) found = 1'b1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL %s: got no frame_tick, required one within 200 cycles", name);
        end
    endtask

    task automatic wait_an(input logic [2:0] val, input string name);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (anodos === val) found = 1'b1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL %s: got no anodos=%b, required within 200 cycles", name, val);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t       rows [6];
        logic [2:0] exp_an;
        logic [7:0] exp_seg;
        int         c0;
        int         c1;
        int         c2;
        int         nt;

        rows[0] = '{4'd15, 3'b000, 64, 64, 64, 4};
        rows[1] = '{4'd4,  3'b000, 16, 16, 16, 4};
        rows[2] = '{4'd0,  3'b000, 0,  0,  0,  4};
        rows[3] = '{4'd15, 3'b010, 64, 32, 64, 4};
        rows[4] = '{4'd8,  3'b101, 16, 32, 16, 4};
        rows[5] = '{4'd1,  3'b111, 2,  2,  2,  4};

        reset         = 1'b1;
        brightness    = 4'd15;
        blink_mask    = 3'b000;
        wr.load       = 1'b0;
        wr.bufdestino = 2'd0;
        wr.datai      = 8'h00;

        // Reset held three cycles: everything dark.
        repeat (3) begin
            @(negedge clk);
            check("rst_anodos", 16'(anodos), 16'h0007);
            check("rst_segs", 16'(segs), 16'h00FF);
            check("rst_tick", 16'(frame_tick), 16'h0000);
        end

        // Release reset and load the three digit patterns.
        reset         = 1'b0;
        wr.load       = 1'b1;
        wr.bufdestino = 2'd0;
        wr.datai      = 8'h3F;
        @(negedge clk);
        wr.bufdestino = 2'd1;
        wr.datai      = 8'h06;
        @(negedge clk);
        wr.bufdestino = 2'd2;
        wr.datai      = 8'h5B;
        @(negedge clk);
        wr.load = 1'b0;

        // One full frame at full brightness, hand-checked slot by slot.
        wait_tick("frame_start");
        for (int j = 0; j < 48; j++) begin
            if (j > 0) @(negedge clk);
            exp_an  = (j < 16) ? 3'b110 : (j < 32) ? 3'b101 : 3'b011;
            exp_seg = (j < 16) ? 8'hC0 : (j < 32) ? 8'hF9 : 8'hA4;
            check("full_anodos", 16'(anodos), 16'(exp_an));
            check("full_segs", 16'(segs), 16'(exp_seg));
            check("full_tick", 16'(frame_tick), (j == 0) ? 16'h0001 : 16'h0000);
        end

        // Brightness/blink table: lit cycles per digit over four whole frames.
        for (int r = 0; r < 6; r++) begin
            brightness = rows[r].bright;
            blink_mask = rows[r].mask;
            wait_tick("row_tick");
            c0 = 0;
            c1 = 0;
            c2 = 0;
            nt = 0;
            for (int j = 0; j < 192; j++) begin
                if (j > 0) @(negedge clk);
                if (anodos === 3'b110) c0++;
                if (anodos === 3'b101) c1++;
                if (anodos === 3'b011) c2++;
                if (frame_tick === 1'b1) nt++;
            end
            check($sformatf("row%0d_lit0", r), 16'(c0), 16'(rows[r].lit0));
            check($sformatf("row%0d_lit1", r), 16'(c1), 16'(rows[r].lit1));
            check($sformatf("row%0d_lit2", r), 16'(c2), 16'(rows[r].lit2));
            check($sformatf("row%0d_ticks", r), 16'(nt), 16'(rows[r].ticks));
        end

        // Write to digit 1 during its own slot: one cycle of output latency.
        brightness = 4'd15;
        blink_mask = 3'b000;
        wait_an(3'b110, "wait_slot0");
        wait_an(3'b101, "wait_slot1");
        wr.load       = 1'b1;
        wr.bufdestino = 2'd1;
        wr.datai      = 8'h7F;
        @(negedge clk);
        wr.load = 1'b0;
        check("load_old_segs", 16'(segs), 16'h00F9);
        @(negedge clk);
        check("load_new_anodos", 16'(anodos), 16'h0005);
        check("load_new_segs", 16'(segs), 16'h0080);

        // Out-of-range index is ignored.
        wr.load       = 1'b1;
        wr.bufdestino = 2'd3;
        wr.datai      = 8'h00;
        @(negedge clk);
        wr.load = 1'b0;
        wait_an(3'b110, "oob_slot0");
        check("oob_digit0", 16'(segs), 16'h00C0);
        wait_an(3'b101, "oob_slot1");
        check("oob_digit1", 16'(segs), 16'h0080);
        wait_an(3'b011, "oob_slot2");
        check("oob_digit2", 16'(segs), 16'h00A4);

        // Reset in the middle of digit 2's slot.
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_anodos", 16'(anodos), 16'h0007);
        check("midrst_segs", 16'(segs), 16'h00FF);
        reset = 1'b0;
        @(negedge clk);
        check("restart_anodos", 16'(anodos), 16'h0006);
        check("restart_segs", 16'(segs), 16'h00FF);
        check("restart_tick", 16'(frame_tick), 16'h0000);
        repeat (60) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
